// File: rtl/mult_pkg.sv
// mult_pkg: shared width parameters and FSM state type for the multiplier scheduler
package mult_pkg;
  localparam int N   = 4;
  localparam int CW  = $clog2(N);
  localparam int IDW = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/shiftadd_core.sv
// shiftadd_core: iterative unsigned shift-add multiplier, one multiplier bit per step
module shiftadd_core
  import mult_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [N-1:0]   m_i,
  input  logic [N-1:0]   q_i,
  output logic           last_o,
  output logic [2*N-1:0] acc_o
);
  logic [N-1:0]   m_q, q_q;
  logic [2*N-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      m_q   <= m_i;
      q_q   <= q_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      if (q_q[cnt_q]) acc_q <= acc_q + ({{N{1'b0}}, m_q} << cnt_q);
      cnt_q <= cnt_q + CW'(1);
    end
  assign last_o = cnt_q == CW'(N - 1);
  assign acc_o  = acc_q;
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one shift-add multiplier between two requesters
module mult_share_sched
  import mult_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [N-1:0]   plicand0_i,
  input  logic [N-1:0]   plier0_i,
  input  logic [N-1:0]   plicand1_i,
  input  logic [N-1:0]   plier1_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [IDW-1:0] rsp_id_o,
  output logic [2*N-1:0] product_o,
  output logic           busy_o
);
  state_e         state_q;
  logic           pri_q, win, take, last;
  logic [IDW-1:0] id_q;
  always_comb begin
    win  = req_valid_i[pri_q] ? pri_q : ~pri_q;
    take = state_q == IDLE && |req_valid_i && !reset_i;
  end
  assign req_ready_o = take ? (win ? 2'b10 : 2'b01) : 2'b00;
  shiftadd_core u_core (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (take),
    .step_i  (state_q == RUN),
    .m_i     (win ? plicand1_i : plicand0_i),
    .q_i     (win ? plier1_i : plier0_i),
    .last_o  (last),
    .acc_o   (product_o)
  );
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      id_q    <= '0;
    end else
      case (state_q)
        IDLE: if (take) begin
          state_q <= RUN;
          id_q    <= win;
          pri_q   <= ~win;
        end
        RUN:     if (last) state_q <= DONE;
        DONE:    if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign rsp_valid_o = state_q == DONE;
  assign rsp_id_o    = id_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: directed and randomized checks of the shared multiplier scheduler
module tb_mult_share_sched;
  logic       clk = 0, reset_i = 1, rsp_ready = 0;
  logic [1:0] req_valid = 0, req_ready;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic       rsp_valid, rsp_id, busy;
  logic [7:0] product;
  int errors = 0, checks = 0;

  mult_share_sched dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .plicand0_i(a0), .plier0_i(b0), .plicand1_i(a1), .plier1_i(b1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .product_o(product), .busy_o(busy)
  );

  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1; req_valid = 0; rsp_ready = 0;
    nxt(); nxt();
    reset_i = 0;
  endtask

  task automatic wait_rsp(output logic [7:0] p, output logic id, output int lat);
    lat = 0;
    rsp_ready = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 30) begin
      nxt(); lat++; @(negedge clk);
    end
    p = product; id = rsp_id;
  endtask

  task automatic test_reset();
    reset_i = 1; req_valid = 2'b11; rsp_ready = 1;
    nxt(); nxt();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, product, busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: actual ready=%b vld=%b id=%b prod=%0d busy=%b required all zero",
               req_ready, rsp_valid, rsp_id, product, busy);
    end
    nxt();
    reset_i = 0; req_valid = 0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: actual ready=%b vld=%b busy=%b required 00/0/0", req_ready, rsp_valid, busy);
    end
    nxt();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; a0 = 13; b0 = 11; rsp_ready = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: actual=%b required=01", req_ready); end
    nxt();
    req_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, rsp_valid} !== 2'b10) begin
        errors++; $display("FAIL single_run%0d: actual busy=%b vld=%b required 1/0", c, busy, rsp_valid);
      end
      nxt();
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, product} !== {1'b1, 1'b0, 8'd143}) begin
      errors++; $display("FAIL single_rsp: actual vld=%b id=%b prod=%0d required 1/0/143", rsp_valid, rsp_id, product);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: actual busy=%b required 0", busy); end
    nxt();
  endtask

  task automatic test_simultaneous();
    logic [7:0] p; logic id; int lat;
    do_reset();
    req_valid = 2'b11; a0 = 15; b0 = 15; a1 = 0; b1 = 9;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_grant0: actual=%b required=01", req_ready); end
    nxt();
    req_valid = 2'b10;
    wait_rsp(p, id, lat);
    checks++;
    if ({rsp_valid, id, p, lat} !== {1'b1, 1'b0, 8'd225, 32'd4}) begin
      errors++; $display("FAIL simul_rsp0: actual vld=%b id=%b prod=%0d lat=%0d required 1/0/225/4", rsp_valid, id, p, lat);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_grant1: actual=%b required=10", req_ready); end
    nxt();
    req_valid = 0;
    wait_rsp(p, id, lat);
    checks++;
    if ({rsp_valid, id, p, lat} !== {1'b1, 1'b1, 8'd0, 32'd4}) begin
      errors++; $display("FAIL simul_rsp1: actual vld=%b id=%b prod=%0d lat=%0d required 1/1/0/4", rsp_valid, id, p, lat);
    end
    nxt();
    req_valid = 2'b11; a0 = 1; b0 = 2; a1 = 3; b1 = 3;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_alt0: actual=%b required=01", req_ready); end
    nxt();
    wait_rsp(p, id, lat);
    checks++;
    if ({id, p} !== {1'b0, 8'd2}) begin errors++; $display("FAIL simul_alt_rsp0: actual id=%b prod=%0d required 0/2", id, p); end
    nxt();
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_alt1: actual=%b required=10", req_ready); end
    nxt();
    req_valid = 0;
    wait_rsp(p, id, lat);
    checks++;
    if ({id, p} !== {1'b1, 8'd9}) begin errors++; $display("FAIL simul_alt_rsp1: actual id=%b prod=%0d required 1/9", id, p); end
    nxt();
  endtask

  task automatic test_backpressure();
    logic [7:0] p; logic id; int lat;
    do_reset();
    req_valid = 2'b01; a0 = 6; b0 = 7; a1 = 2; b1 = 2;
    nxt();
    req_valid = 2'b10; rsp_ready = 0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 30) begin nxt(); lat++; @(negedge clk); end
    for (int c = 0; c < 7; c++) begin
      checks++;
      if ({rsp_valid, rsp_id, product, req_ready} !== {1'b1, 1'b0, 8'd42, 2'b00}) begin
        errors++; $display("FAIL bp_hold%0d: actual vld=%b id=%b prod=%0d ready=%b required 1/0/42/00",
                           c, rsp_valid, rsp_id, product, req_ready);
      end
      nxt(); @(negedge clk);
    end
    rsp_ready = 1;
    nxt();
    @(negedge clk);
    checks++;
    if ({busy, req_ready} !== 3'b010) begin
      errors++; $display("FAIL bp_accept: actual busy=%b ready=%b required 0/10", busy, req_ready);
    end
    nxt();
    req_valid = 0;
    wait_rsp(p, id, lat);
    checks++;
    if ({rsp_valid, id, p} !== {1'b1, 1'b1, 8'd4}) begin
      errors++; $display("FAIL bp_next: actual vld=%b id=%b prod=%0d required 1/1/4", rsp_valid, id, p);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    logic [7:0] p; logic id; int lat; int seen;
    do_reset();
    req_valid = 2'b01; a0 = 9; b0 = 5; rsp_ready = 1;
    nxt();
    req_valid = 0;
    nxt();
    reset_i = 1;
    nxt();
    reset_i = 0;
    @(negedge clk);
    checks++;
    if ({busy, rsp_valid, product} !== 10'b0) begin
      errors++; $display("FAIL midreset_clear: actual busy=%b vld=%b prod=%0d required 0/0/0", busy, rsp_valid, product);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin nxt(); @(negedge clk); seen += rsp_valid; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midreset_norsp: actual=%0d responses required=0", seen); end
    nxt();
    req_valid = 2'b01; a0 = 3; b0 = 3;
    nxt();
    req_valid = 0;
    wait_rsp(p, id, lat);
    checks++;
    if ({rsp_valid, id, p} !== {1'b1, 1'b0, 8'd9}) begin
      errors++; $display("FAIL midreset_fresh: actual vld=%b id=%b prod=%0d required 1/0/9", rsp_valid, id, p);
    end
    nxt();
  endtask

  task automatic test_withdrawn();
    logic [7:0] p; logic id; int lat; int seen;
    do_reset();
    req_valid = 2'b01; a0 = 5; b0 = 6; a1 = 7; b1 = 7; rsp_ready = 1;
    nxt();
    req_valid = 0;
    nxt();
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL withdrawn_busy_ready: actual=%b required=00", req_ready); end
    nxt();
    req_valid = 0;
    wait_rsp(p, id, lat);
    checks++;
    if ({rsp_valid, id, p} !== {1'b1, 1'b0, 8'd30}) begin
      errors++; $display("FAIL withdrawn_req0: actual vld=%b id=%b prod=%0d required 1/0/30", rsp_valid, id, p);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin nxt(); @(negedge clk); seen += busy; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL withdrawn_nogrant: actual busy cycles=%0d required=0", seen); end
    nxt();
  endtask

  task automatic test_exhaustive();
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int k[2];
    int done, cyc;
    logic mpri, w;
    do_reset();
    k[0] = 0; k[1] = 1; done = 0; cyc = 0; mpri = 0;
    while (done < 256 && cyc < 20000) begin
      req_valid = {k[1] < 256, k[0] < 256};
      a0 = k[0][7:4]; b0 = k[0][3:0];
      a1 = k[1][7:4]; b1 = k[1][3:0];
      rsp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        w = req_valid[mpri] ? mpri : ~mpri;
        checks++;
        if (req_ready !== (w ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL exh_grant: actual=%b required=%b", req_ready, w ? 2'b10 : 2'b01);
        end
        exp_q.push_back({w, 8'(k[w][7:4] * k[w][3:0])});
        mpri = ~w;
        k[w] += 2;
      end
      if (rsp_valid && rsp_ready) begin
        e = exp_q.size() ? exp_q.pop_front() : 9'h1ff;
        checks++;
        if ({rsp_id, product} !== e) begin
          errors++; $display("FAIL exh_rsp%0d: actual id=%b prod=%0d required id=%b prod=%0d",
                             done, rsp_id, product, e[8], e[7:0]);
        end
        done++;
      end
      nxt();
      cyc++;
    end
    req_valid = 0; rsp_ready = 0;
    checks++;
    if (done !== 256) begin errors++; $display("FAIL exh_count: actual=%0d responses required=256", done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_withdrawn();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
